// File: rtl/raster_stamp_csr_buf.sv
// Per-warp, per-lane staging buffer for raster quad stamps, read back through
// a registered 32-bit CSR window (position/mask, primitive id, barycentrics).
module raster_stamp_csr_buf #(
   parameter int NUM_WARPS = 4,
   parameter int NUM_LANES = 4,
   parameter int DIM_BITS  = 12,
   parameter int PID_BITS  = 8,
   localparam int WID_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  stamp_valid,
   output logic                  stamp_ready,
   input  logic [WID_BITS-1:0]   stamp_wid,
   input  logic [LANE_BITS-1:0]  stamp_lane,
   input  logic [DIM_BITS-2:0]   stamp_pos_x,
   input  logic [DIM_BITS-2:0]   stamp_pos_y,
   input  logic [3:0]            stamp_mask,
   input  logic [127:0]          stamp_bcoord_x,
   input  logic [127:0]          stamp_bcoord_y,
   input  logic [127:0]          stamp_bcoord_z,
   input  logic [PID_BITS-1:0]   stamp_pid,
   input  logic                  rel_valid,
   input  logic [WID_BITS-1:0]   rel_wid,
   input  logic                  rd_valid,
   input  logic [WID_BITS-1:0]   rd_wid,
   input  logic [LANE_BITS-1:0]  rd_lane,
   input  logic [3:0]            rd_idx,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_data,
   output logic                  rsp_hit,
   output logic [NUM_WARPS-1:0]  warp_full
);

   localparam int POS_BITS  = DIM_BITS - 1;
   localparam int NUM_SLOTS = NUM_WARPS * NUM_LANES;
   localparam int SLOT_BITS = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   slot_state_e              slot_q [NUM_SLOTS];
   slot_state_e              slot_d [NUM_SLOTS];
   logic [NUM_WARPS-1:0]     warp_full_d;

   logic [POS_BITS-1:0]      pos_x_q  [NUM_SLOTS];
   logic [POS_BITS-1:0]      pos_y_q  [NUM_SLOTS];
   logic [3:0]               mask_q   [NUM_SLOTS];
   logic [PID_BITS-1:0]      pid_q    [NUM_SLOTS];
   logic [127:0]             bc_x_q   [NUM_SLOTS];
   logic [127:0]             bc_y_q   [NUM_SLOTS];
   logic [127:0]             bc_z_q   [NUM_SLOTS];

   logic                     wr_wid_ok, wr_lane_ok, wr_ok;
   logic                     rd_wid_ok, rd_lane_ok, rd_ok;
   logic [SLOT_BITS-1:0]     wr_slot, rd_slot;
   logic                     stamp_fire;
   logic                     rd_hit;
   logic [31:0]              rd_word;
   logic [1:0]               bc_sel;

   function automatic logic [SLOT_BITS-1:0] slot_of(input logic [WID_BITS-1:0]  w,
                                                    input logic [LANE_BITS-1:0] l);
      int unsigned s;
      s = 32'(w) * 32'(NUM_LANES) + 32'(l);
      return SLOT_BITS'(s);
   endfunction

   // Range checks only exist when a count is not a power of two.
   if (NUM_WARPS == (1 << WID_BITS)) begin : g_wid_pow2
      assign wr_wid_ok = 1'b1;
      assign rd_wid_ok = 1'b1;
   end else begin : g_wid_chk
      assign wr_wid_ok = (32'(stamp_wid) < 32'(NUM_WARPS));
      assign rd_wid_ok = (32'(rd_wid) < 32'(NUM_WARPS));
   end

   if (NUM_LANES == (1 << LANE_BITS)) begin : g_lane_pow2
      assign wr_lane_ok = 1'b1;
      assign rd_lane_ok = 1'b1;
   end else begin : g_lane_chk
      assign wr_lane_ok = (32'(stamp_lane) < 32'(NUM_LANES));
      assign rd_lane_ok = (32'(rd_lane) < 32'(NUM_LANES));
   end

   assign wr_ok   = wr_wid_ok && wr_lane_ok;
   assign rd_ok   = rd_wid_ok && rd_lane_ok;
   assign wr_slot = wr_ok ? slot_of(stamp_wid, stamp_lane) : '0;
   assign rd_slot = rd_ok ? slot_of(rd_wid, rd_lane) : '0;

   assign stamp_ready = wr_ok && (slot_q[wr_slot] == SLOT_EMPTY) &&
                        !(rel_valid && (rel_wid == stamp_wid));
   assign stamp_fire  = stamp_valid && stamp_ready;

   // Next slot occupancy; a fire never targets a warp being released.
   always_comb begin
      slot_d      = slot_q;
      warp_full_d = '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         logic all_full;
         all_full = 1'b1;
         for (int unsigned l = 0; l < NUM_LANES; l++) begin
            int unsigned idx;
            idx = w * NUM_LANES + l;
            if (rel_valid && (32'(rel_wid) == w))
               slot_d[idx] = SLOT_EMPTY;
            if (stamp_fire && (wr_slot == SLOT_BITS'(idx)))
               slot_d[idx] = SLOT_FULL;
            if (slot_d[idx] != SLOT_FULL)
               all_full = 1'b0;
         end
         if (all_full)
            warp_full_d = warp_full_d | (NUM_WARPS'(1) << w);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_q    <= '{default: SLOT_EMPTY};
         warp_full <= '0;
      end else begin
         slot_q    <= slot_d;
         warp_full <= warp_full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (stamp_fire) begin
         pos_x_q[wr_slot] <= stamp_pos_x;
         pos_y_q[wr_slot] <= stamp_pos_y;
         mask_q[wr_slot]  <= stamp_mask;
         pid_q[wr_slot]   <= stamp_pid;
         bc_x_q[wr_slot]  <= stamp_bcoord_x;
         bc_y_q[wr_slot]  <= stamp_bcoord_y;
         bc_z_q[wr_slot]  <= stamp_bcoord_z;
      end
   end

   assign rd_hit = rd_ok && (slot_q[rd_slot] == SLOT_FULL);

   always_comb begin
      rd_word = '0;
      bc_sel  = '0;
      case (rd_idx)
         4'd0: begin
            rd_word[3:0]                   = mask_q[rd_slot];
            rd_word[4 +: POS_BITS]          = pos_x_q[rd_slot];
            rd_word[4 + POS_BITS +: POS_BITS] = pos_y_q[rd_slot];
         end
         4'd1: rd_word[PID_BITS-1:0] = pid_q[rd_slot];
         4'd2, 4'd3, 4'd4, 4'd5: begin
            bc_sel  = 2'(rd_idx - 4'd2);
            rd_word = bc_x_q[rd_slot][{bc_sel, 5'd0} +: 32];
         end
         4'd6, 4'd7, 4'd8, 4'd9: begin
            bc_sel  = 2'(rd_idx - 4'd6);
            rd_word = bc_y_q[rd_slot][{bc_sel, 5'd0} +: 32];
         end
         4'd10, 4'd11, 4'd12, 4'd13: begin
            bc_sel  = 2'(rd_idx - 4'd10);
            rd_word = bc_z_q[rd_slot][{bc_sel, 5'd0} +: 32];
         end
         default: rd_word = '0;
      endcase
      if (!rd_hit)
         rd_word = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_hit   <= 1'b0;
      end else begin
         rsp_valid <= rd_valid;
         if (rd_valid) begin
            rsp_data <= rd_word;
            rsp_hit  <= rd_hit;
         end
      end
   end

endmodule

// File: tb/tb_raster_stamp_csr_buf.sv
// Scoreboard bench for raster_stamp_csr_buf: a 4x4 build plus a 3-warp build
// for out-of-range warp ids.
module tb_raster_stamp_csr_buf;

   localparam int CX = 1;
   localparam int CY = 2;
   localparam int CZ = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          stamp_valid, stamp_ready;
   logic [1:0]    stamp_wid, stamp_lane;
   logic [10:0]   stamp_pos_x, stamp_pos_y;
   logic [3:0]    stamp_mask;
   logic [127:0]  stamp_bcoord_x, stamp_bcoord_y, stamp_bcoord_z;
   logic [7:0]    stamp_pid;
   logic          rel_valid;
   logic [1:0]    rel_wid;
   logic          rd_valid;
   logic [1:0]    rd_wid, rd_lane;
   logic [3:0]    rd_idx;
   logic          rsp_valid, rsp_hit;
   logic [31:0]   rsp_data;
   logic [3:0]    warp_full;

   logic          u3_stamp_valid, u3_stamp_ready;
   logic [1:0]    u3_stamp_wid, u3_stamp_lane;
   logic [10:0]   u3_pos_x, u3_pos_y;
   logic [3:0]    u3_mask;
   logic [127:0]  u3_bc;
   logic [7:0]    u3_pid;
   logic          u3_rel_valid;
   logic [1:0]    u3_rel_wid;
   logic          u3_rd_valid;
   logic [1:0]    u3_rd_wid, u3_rd_lane;
   logic [3:0]    u3_rd_idx;
   logic          u3_rsp_valid, u3_rsp_hit;
   logic [31:0]   u3_rsp_data;
   logic [2:0]    u3_warp_full;

   int n_checks = 0;
   int n_fail   = 0;
   logic [32:0] sb[$];

   raster_stamp_csr_buf #(.NUM_WARPS(4), .NUM_LANES(4), .DIM_BITS(12), .PID_BITS(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .stamp_valid(stamp_valid), .stamp_ready(stamp_ready),
      .stamp_wid(stamp_wid), .stamp_lane(stamp_lane),
      .stamp_pos_x(stamp_pos_x), .stamp_pos_y(stamp_pos_y), .stamp_mask(stamp_mask),
      .stamp_bcoord_x(stamp_bcoord_x), .stamp_bcoord_y(stamp_bcoord_y),
      .stamp_bcoord_z(stamp_bcoord_z), .stamp_pid(stamp_pid),
      .rel_valid(rel_valid), .rel_wid(rel_wid),
      .rd_valid(rd_valid), .rd_wid(rd_wid), .rd_lane(rd_lane), .rd_idx(rd_idx),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
      .warp_full(warp_full)
   );

   raster_stamp_csr_buf #(.NUM_WARPS(3), .NUM_LANES(4), .DIM_BITS(12), .PID_BITS(8)) u3 (
      .clk(clk), .reset_n(reset_n),
      .stamp_valid(u3_stamp_valid), .stamp_ready(u3_stamp_ready),
      .stamp_wid(u3_stamp_wid), .stamp_lane(u3_stamp_lane),
      .stamp_pos_x(u3_pos_x), .stamp_pos_y(u3_pos_y), .stamp_mask(u3_mask),
      .stamp_bcoord_x(u3_bc), .stamp_bcoord_y(u3_bc), .stamp_bcoord_z(u3_bc),
      .stamp_pid(u3_pid),
      .rel_valid(u3_rel_valid), .rel_wid(u3_rel_wid),
      .rd_valid(u3_rd_valid), .rd_wid(u3_rd_wid), .rd_lane(u3_rd_lane), .rd_idx(u3_rd_idx),
      .rsp_valid(u3_rsp_valid), .rsp_data(u3_rsp_data), .rsp_hit(u3_rsp_hit),
      .warp_full(u3_warp_full)
   );

   function automatic logic [31:0] bc(input int c, input int w, input int l, input int i);
      return 32'hB000_0000 | (32'(c) << 16) | (32'(w) << 8) | (32'(l) << 4) | 32'(i);
   endfunction

   function automatic logic [127:0] bvec(input int c, input int w, input int l);
      logic [127:0] v;
      for (int i = 0; i < 4; i++) v[32*i +: 32] = bc(c, w, l, i);
      return v;
   endfunction

   function automatic logic [31:0] pack_pm(input int px, input int py, input int m);
      return 32'(m) | (32'(px) << 4) | (32'(py) << 15);
   endfunction

   task automatic idle();
      stamp_valid = 1'b0;
      rel_valid   = 1'b0;
      rd_valid    = 1'b0;
   endtask

   task automatic drive_write(input int w, input int l, input int px, input int py,
                              input int m, input int pid);
      stamp_valid    = 1'b1;
      stamp_wid      = 2'(w);
      stamp_lane     = 2'(l);
      stamp_pos_x    = 11'(px);
      stamp_pos_y    = 11'(py);
      stamp_mask     = 4'(m);
      stamp_pid      = 8'(pid);
      stamp_bcoord_x = bvec(CX, w, l);
      stamp_bcoord_y = bvec(CY, w, l);
      stamp_bcoord_z = bvec(CZ, w, l);
   endtask

   task automatic drive_rd(input int w, input int l, input int idx);
      rd_valid = 1'b1;
      rd_wid   = 2'(w);
      rd_lane  = 2'(l);
      rd_idx   = 4'(idx);
   endtask

   // Response consumer: every rsp_valid pops one expected {hit, data}.
   always @(negedge clk) begin
      if (reset_n && rsp_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: got data=%h hit=%b, none required", rsp_data, rsp_hit);
         end else begin
            logic [32:0] exp;
            exp = sb.pop_front();
            if ({rsp_hit, rsp_data} !== exp) begin
               n_fail++;
               $display("FAIL rsp_scoreboard: got data=%h hit=%b, required data=%h hit=%b",
                        rsp_data, rsp_hit, exp[31:0], exp[32]);
            end
         end
      end
   end

   task automatic test_reset();
      #2;
      n_checks++;
      if ({rsp_valid, rsp_hit, rsp_data, warp_full} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b hit=%b data=%h full=%b, required all 0",
                  rsp_valid, rsp_hit, rsp_data, warp_full);
      end
      n_checks++;
      if (stamp_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b, required 1", stamp_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      drive_write(1, 2, 5, 3, 4'hA, 7);
      #1;
      n_checks++;
      if (stamp_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_ready: got %b, required 1", stamp_ready);
      end
      @(negedge clk);
      idle();
      drive_rd(1, 2, 0);
      sb.push_back({1'b1, pack_pm(5, 3, 4'hA)});
      @(negedge clk);
      drive_rd(1, 2, 1);
      sb.push_back({1'b1, 32'd7});
      @(negedge clk);
      idle();
   endtask

   task automatic test_fill_full();
      for (int l = 0; l < 4; l++) begin
         @(negedge clk);
         drive_write(0, l, l + 1, l + 2, 4'hF, 16 + l);
         #1;
         n_checks++;
         if (stamp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_ready lane%0d: got %b, required 1", l, stamp_ready);
         end
      end
      @(negedge clk);
      drive_write(0, 1, 9, 9, 4'h1, 99);
      drive_rd(0, 3, 7);
      sb.push_back({1'b1, bc(CY, 0, 3, 1)});
      #1;
      n_checks++;
      if (stamp_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL repeat_ready: got %b, required 0", stamp_ready);
      end
      n_checks++;
      if (warp_full !== 4'b0001) begin
         n_fail++;
         $display("FAIL warp_full_w0: got %b, required 0001", warp_full);
      end
      @(negedge clk);
      idle();
      drive_rd(0, 1, 1);
      sb.push_back({1'b1, 32'd17});
      @(negedge clk);
      idle();
   endtask

   task automatic test_release_same_cycle();
      @(negedge clk);
      rel_valid = 1'b1;
      rel_wid   = 2'd0;
      drive_write(0, 0, 1, 1, 4'h3, 50);
      drive_rd(0, 0, 2);
      sb.push_back({1'b1, bc(CX, 0, 0, 0)});
      #1;
      n_checks++;
      if (stamp_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_wr_ready: got %b, required 0", stamp_ready);
      end
      @(negedge clk);
      idle();
      drive_rd(0, 0, 2);
      sb.push_back({1'b0, 32'd0});
      n_checks++;
      if (warp_full !== 4'b0000) begin
         n_fail++;
         $display("FAIL rel_warp_full: got %b, required 0000", warp_full);
      end
      @(negedge clk);
      idle();
      rel_valid = 1'b1;
      rel_wid   = 2'd0;
      drive_write(3, 0, 7, 7, 4'h5, 33);
      #1;
      n_checks++;
      if (stamp_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rel_other_ready: got %b, required 1", stamp_ready);
      end
      @(negedge clk);
      idle();
      drive_rd(3, 0, 0);
      sb.push_back({1'b1, pack_pm(7, 7, 4'h5)});
      @(negedge clk);
      idle();
   endtask

   task automatic test_back_to_back_reads();
      @(negedge clk); drive_rd(1, 2, 1);  sb.push_back({1'b1, 32'd7});
      @(negedge clk); drive_rd(3, 1, 0);  sb.push_back({1'b0, 32'd0});
      @(negedge clk); drive_rd(1, 2, 13); sb.push_back({1'b1, bc(CZ, 1, 2, 3)});
      @(negedge clk); drive_rd(1, 2, 14); sb.push_back({1'b1, 32'd0});
      @(negedge clk); drive_rd(1, 2, 6);  sb.push_back({1'b1, bc(CY, 1, 2, 0)});
      @(negedge clk);
      idle();
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== bc(CY, 1, 2, 0)) begin
         n_fail++;
         $display("FAIL rsp_hold: got valid=%b data=%h, required valid=0 data=%h",
                  rsp_valid, rsp_data, bc(CY, 1, 2, 0));
      end
   endtask

   task automatic test_async_reset();
      for (int l = 0; l < 4; l++) begin
         @(negedge clk);
         drive_write(2, l, l, l, 4'h6, 40 + l);
         #1;
         n_checks++;
         if (stamp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL w2_ready lane%0d: got %b, required 1", l, stamp_ready);
         end
      end
      @(negedge clk);
      idle();
      n_checks++;
      if (warp_full !== 4'b0100) begin
         n_fail++;
         $display("FAIL warp_full_w2: got %b, required 0100", warp_full);
      end
      drive_rd(2, 1, 6);
      @(posedge clk);
      #2;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_rsp: got valid=%b hit=%b, required 1 1", rsp_valid, rsp_hit);
      end
      reset_n  = 1'b0;
      rd_valid = 1'b0;
      #1;
      n_checks++;
      if ({rsp_valid, rsp_hit, rsp_data, warp_full} !== 38'd0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b hit=%b data=%h full=%b, required all 0",
                  rsp_valid, rsp_hit, rsp_data, warp_full);
      end
      @(negedge clk);
      reset_n     = 1'b1;
      stamp_wid   = 2'd2;
      stamp_lane  = 2'd1;
      drive_rd(1, 2, 0);
      sb.push_back({1'b0, 32'd0});
      #1;
      n_checks++;
      if (stamp_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_ready: got %b, required 1", stamp_ready);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_nonpow2();
      @(negedge clk);
      u3_stamp_valid = 1'b1;
      u3_stamp_wid   = 2'd2;
      u3_stamp_lane  = 2'd0;
      #1;
      n_checks++;
      if (u3_stamp_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL u3_ready_w2: got %b, required 1", u3_stamp_ready);
      end
      @(negedge clk);
      u3_stamp_wid = 2'd3;
      u3_rd_valid  = 1'b1;
      u3_rd_wid    = 2'd2;
      u3_rd_lane   = 2'd0;
      u3_rd_idx    = 4'd0;
      #1;
      n_checks++;
      if (u3_stamp_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL u3_ready_w3: got %b, required 0", u3_stamp_ready);
      end
      @(negedge clk);
      u3_stamp_valid = 1'b0;
      u3_rd_wid      = 2'd3;
      n_checks++;
      if (u3_rsp_valid !== 1'b1 || u3_rsp_data !== 32'h0000_000F || u3_rsp_hit !== 1'b1) begin
         n_fail++;
         $display("FAIL u3_rd_w2: got valid=%b data=%h hit=%b, required 1 0000000f 1",
                  u3_rsp_valid, u3_rsp_data, u3_rsp_hit);
      end
      @(negedge clk);
      u3_rd_valid = 1'b0;
      n_checks++;
      if (u3_rsp_valid !== 1'b1 || u3_rsp_data !== 32'd0 || u3_rsp_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL u3_rd_w3: got valid=%b data=%h hit=%b, required 1 00000000 0",
                  u3_rsp_valid, u3_rsp_data, u3_rsp_hit);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      idle();
      drive_write(0, 0, 0, 0, 0, 0);
      stamp_valid = 1'b0;
      drive_rd(0, 0, 0);
      rd_valid = 1'b0;
      rel_wid  = 2'd0;
      u3_stamp_valid = 1'b0; u3_stamp_wid = 2'd0; u3_stamp_lane = 2'd0;
      u3_pos_x = 11'd0; u3_pos_y = 11'd0; u3_mask = 4'hF; u3_bc = '0; u3_pid = 8'd1;
      u3_rel_valid = 1'b0; u3_rel_wid = 2'd0;
      u3_rd_valid = 1'b0; u3_rd_wid = 2'd0; u3_rd_lane = 2'd0; u3_rd_idx = 4'd0;

      test_reset();
      test_write_read();
      test_fill_full();
      test_release_same_cycle();
      test_back_to_back_reads();
      test_async_reset();
      test_nonpow2();

      repeat (3) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending responses, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
